// File: rtl/render_seq_pkg.sv
// Shared types and sizing helpers for the render frame sequencer.
package render_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    LAUNCH   = 3'd2,
    WAIT_OBJ = 3'd3,
    DONE     = 3'd4
  } seq_state_t;

  function automatic int fb_size(input int width, input int height);
    return width * height;
  endfunction

  function automatic int obj_w(input int max_objects);
    return $clog2(max_objects + 1);
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Linear framebuffer clear sweep: one write per cycle over addresses 0..FB_SIZE-1 after a start pulse.
module fb_clear_engine #(
  parameter int FB_SIZE   = 19200,
  parameter int ADDRWIDTH = $clog2(FB_SIZE)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  output logic                 o_we,
  output logic [ADDRWIDTH-1:0] o_addr,
  output logic                 o_last
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(FB_SIZE - 1);

  logic                 we_q, we_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;

  // The sweep stops on the last address and holds there rather than wrapping.
  always_comb begin
    we_d   = we_q;
    addr_d = addr_q;
    if (i_start) begin
      we_d   = 1'b1;
      addr_d = '0;
    end else if (we_q) begin
      if (addr_q == LAST_ADDR) begin
        we_d = 1'b0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
    end
  end

  assign o_we   = we_q;
  assign o_addr = addr_q;
  assign o_last = we_q && (addr_q == LAST_ADDR);

endmodule

// File: rtl/render_frame_sequencer.sv
// Per-frame controller: clear framebuffer, then launch render_pipeline once per object.
// Optional FRAME_SEQ_CYCLE_COUNT_EN adds the o_frame_cycles busy-cycle counter output.
module render_frame_sequencer
  import render_seq_pkg::*;
#(
  parameter int SCREEN_WIDTH     = 160,
  parameter int SCREEN_HEIGHT    = 120,
  parameter int ADDRWIDTH        = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
  parameter int OUTPUT_DATAWIDTH = 12,
  parameter int COLORWIDTH       = 4,
  parameter int CLEAR_COLOR      = 0,
  parameter int MAX_NUM_OBJECTS  = 1024,
  parameter int OBJ_W            = obj_w(MAX_NUM_OBJECTS)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_frame_valid,
  output logic                        o_frame_ready,
  input  logic [OBJ_W-1:0]            i_num_objects,
  input  logic                        i_pipe_ready,
  input  logic                        i_pipe_finished,
  output logic                        o_obj_start,
  output logic [OBJ_W-1:0]            o_obj_index,
  output logic                        o_clr_we,
  output logic [ADDRWIDTH-1:0]        o_clr_addr,
  output logic [OUTPUT_DATAWIDTH-1:0] o_clr_depth,
  output logic [COLORWIDTH-1:0]       o_clr_color,
  output logic                        o_busy,
  output logic                        o_frame_done
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]                 o_frame_cycles
`endif
);

  localparam int               FB_SIZE = fb_size(SCREEN_WIDTH, SCREEN_HEIGHT);
  localparam logic [OBJ_W-1:0] MAX_OBJ = OBJ_W'(MAX_NUM_OBJECTS);

  seq_state_t       state_q, state_d;
  logic [OBJ_W-1:0] num_q, num_d;
  logic [OBJ_W-1:0] obj_cnt_q, obj_cnt_d;
  logic [OBJ_W-1:0] obj_index_q, obj_index_d;
  logic             obj_start_q, obj_start_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;
  logic             clr_last;

  assign o_frame_ready = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign accept        = i_frame_valid && o_frame_ready;

  fb_clear_engine #(
    .FB_SIZE  (FB_SIZE),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_clear (
    .clk    (clk),
    .rstn   (rstn),
    .i_start(accept),
    .o_we   (o_clr_we),
    .o_addr (o_clr_addr),
    .o_last (clr_last)
  );

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    obj_cnt_d   = obj_cnt_q;
    obj_index_d = obj_index_q;
    obj_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          num_d     = (i_num_objects > MAX_OBJ) ? MAX_OBJ : i_num_objects;
          obj_cnt_d = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_last) state_d = (num_q == '0) ? DONE : LAUNCH;
      end
      LAUNCH: begin
        if (i_pipe_ready) begin
          obj_start_d = 1'b1;
          obj_index_d = obj_cnt_q;
          state_d     = WAIT_OBJ;
        end
      end
      WAIT_OBJ: begin
        // A finished pulse coincident with our start belongs to the previous object.
        if (i_pipe_finished && !obj_start_q) begin
          if (obj_cnt_q == num_q - 1'b1) begin
            state_d = DONE;
          end else begin
            obj_cnt_d = obj_cnt_q + 1'b1;
            state_d   = LAUNCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      num_q        <= '0;
      obj_cnt_q    <= '0;
      obj_index_q  <= '0;
      obj_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      obj_cnt_q    <= obj_cnt_d;
      obj_index_q  <= obj_index_d;
      obj_start_q  <= obj_start_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_obj_start  = obj_start_q;
  assign o_obj_index  = obj_index_q;
  assign o_frame_done = frame_done_q;
  assign o_clr_depth  = '1;
  assign o_clr_color  = COLORWIDTH'(CLEAR_COLOR);

`ifdef FRAME_SEQ_CYCLE_COUNT_EN
  logic [31:0] frame_cycles_q, frame_cycles_d;

  // Counts busy cycles of the current frame, saturating; value survives IDLE.
  always_comb begin
    frame_cycles_d = frame_cycles_q;
    if (accept) begin
      frame_cycles_d = '0;
    end else if (state_q != IDLE && frame_cycles_q != '1) begin
      frame_cycles_d = frame_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) frame_cycles_q <= '0;
    else       frame_cycles_q <= frame_cycles_d;
  end

  assign o_frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Randomized self-checking bench for render_frame_sequencer against a frame-timing schedule model.
module tb_render_frame_sequencer;

  localparam int W     = 32;
  localparam int H     = 24;
  localparam int FB    = W * H;
  localparam int AW    = $clog2(FB);
  localparam int MAXO  = 1024;
  localparam int OBJ_W = $clog2(MAXO + 1);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_frame_valid = 1'b0;
  logic             o_frame_ready;
  logic [OBJ_W-1:0] i_num_objects = '0;
  logic             i_pipe_ready = 1'b0;
  logic             i_pipe_finished = 1'b0;
  logic             o_obj_start;
  logic [OBJ_W-1:0] o_obj_index;
  logic             o_clr_we;
  logic [AW-1:0]    o_clr_addr;
  logic [11:0]      o_clr_depth;
  logic [3:0]       o_clr_color;
  logic             o_busy;
  logic             o_frame_done;
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
  logic [31:0]      o_frame_cycles;
`endif

  render_frame_sequencer #(
    .SCREEN_WIDTH   (W),
    .SCREEN_HEIGHT  (H),
    .MAX_NUM_OBJECTS(MAXO)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_frame_valid  (i_frame_valid),
    .o_frame_ready  (o_frame_ready),
    .i_num_objects  (i_num_objects),
    .i_pipe_ready   (i_pipe_ready),
    .i_pipe_finished(i_pipe_finished),
    .o_obj_start    (o_obj_start),
    .o_obj_index    (o_obj_index),
    .o_clr_we       (o_clr_we),
    .o_clr_addr     (o_clr_addr),
    .o_clr_depth    (o_clr_depth),
    .o_clr_color    (o_clr_color),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done)
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
    ,
    .o_frame_cycles (o_frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  // Per-object plan: cycles pipe_ready stays low after LAUNCH, and finish delay after start.
  int plan_w[MAXO];
  int plan_f[MAXO];

  // Model outputs.
  int exp_launch[$];
  int exp_start[$];
  int exp_done;

  // Observations of the current frame.
  int obs_clr_cyc[$];
  int obs_clr_addr[$];
  int obs_start_cyc[$];
  int obs_start_idx[$];
  int obs_done_cyc[$];
  int obs_reaccept;
  bit timed_out;

  // Frame timeline: accept at 0, clear 1..FB, then per object
  // LAUNCH for w+1 cycles, start, finish f cycles later, next LAUNCH after that.
  task automatic build_schedule(input int n);
    int l;
    exp_launch.delete();
    exp_start.delete();
    l = FB + 1;
    for (int k = 0; k < n; k++) begin
      exp_launch.push_back(l);
      exp_start.push_back(l + plan_w[k] + 1);
      l = l + plan_w[k] + 1 + plan_f[k] + 1;
    end
    exp_done = (n == 0) ? FB + 1 : l;
  endtask

  function automatic int count_bad_clear();
    int bad = 0;
    for (int i = 0; i < obs_clr_addr.size(); i++)
      if (obs_clr_addr[i] != i || obs_clr_cyc[i] != i + 1) bad++;
    return bad;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one frame request at the current cycle (cycle 0) and act as render_pipeline per plan.
  task automatic run_frame(input int num_req, input int n_eff, input bit hold_valid, input bit stale);
    int  k = 0;
    bit  done_seen = 0;
    int  done_cyc = 0;
    bit  rdy, fin;
    obs_clr_cyc.delete(); obs_clr_addr.delete();
    obs_start_cyc.delete(); obs_start_idx.delete(); obs_done_cyc.delete();
    obs_reaccept = -1;
    timed_out = 0;
    build_schedule(n_eff);
    cyc = 0;
    i_frame_valid   = 1'b1;
    i_num_objects   = OBJ_W'(num_req);
    i_pipe_ready    = 1'b0;
    i_pipe_finished = 1'b0;
    forever begin
      step();
      if (done_seen && o_clr_we && obs_reaccept < 0) obs_reaccept = cyc - 1;
      if (o_clr_we && !done_seen) begin
        obs_clr_cyc.push_back(cyc);
        obs_clr_addr.push_back(int'(o_clr_addr));
      end
      if (o_obj_start && !done_seen) begin
        obs_start_cyc.push_back(cyc);
        obs_start_idx.push_back(int'(o_obj_index));
      end
      if (o_frame_done) begin
        obs_done_cyc.push_back(cyc);
        if (!done_seen) done_cyc = cyc;
        done_seen = 1;
      end
      if (done_seen && cyc >= done_cyc + 2) break;
      if (cyc > exp_done + 200) begin
        timed_out = 1;
        break;
      end
      i_frame_valid = hold_valid;
      rdy = 1'b0;
      fin = 1'b0;
      if (k < n_eff) begin
        rdy = (cyc >= exp_launch[k] + plan_w[k]);
        fin = (cyc == exp_start[k] + plan_f[k]);
        if (stale && (cyc == exp_start[k] || (plan_w[k] > 0 && cyc == exp_launch[k]))) fin = 1'b1;
      end
      if (stale && cyc == 5) fin = 1'b1;
      i_pipe_ready    = rdy;
      i_pipe_finished = fin;
      if (k < n_eff && cyc == exp_start[k] + plan_f[k]) k++;
    end
    i_frame_valid   = 1'b0;
    i_pipe_ready    = 1'b0;
    i_pipe_finished = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o_busy, o_clr_we, o_obj_start, o_frame_done} !== 4'b0000) $display("FAIL reset_flags got=%b want=0000", {o_busy, o_clr_we, o_obj_start, o_frame_done});
    else n_pass++;
    n_checks++;
    if (o_obj_index !== '0 || o_clr_addr !== '0) $display("FAIL reset_index_addr got idx=%0d addr=%0d want 0/0", o_obj_index, o_clr_addr);
    else n_pass++;
    rstn = 1'b1;
    step();
    n_checks++;
    if (o_frame_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", o_frame_ready);
    else n_pass++;
    n_checks++;
    if (o_clr_depth !== 12'hFFF || o_clr_color !== 4'h0) $display("FAIL clear_values got depth=%h color=%h want fff/0", o_clr_depth, o_clr_color);
    else n_pass++;
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
    n_checks++;
    if (o_frame_cycles !== 32'd0) $display("FAIL reset_cycles got=%0d want=0", o_frame_cycles);
    else n_pass++;
`endif
    $display("test_reset done");
  endtask

  task automatic test_basic();
    for (int k = 0; k < 3; k++) begin plan_w[k] = 0; plan_f[k] = 10; end
    run_frame(3, 3, 1'b0, 1'b0);
    n_checks++;
    if (timed_out || obs_clr_addr.size() != FB) $display("FAIL basic_clear_count got=%0d want=%0d timeout=%0d", obs_clr_addr.size(), FB, timed_out);
    else n_pass++;
    n_checks++;
    if (count_bad_clear() != 0) $display("FAIL basic_clear_seq got bad=%0d want=0", count_bad_clear());
    else n_pass++;
    n_checks++;
    if (obs_start_cyc.size() != 3) $display("FAIL basic_start_count got=%0d want=3", obs_start_cyc.size());
    else n_pass++;
    for (int k = 0; k < obs_start_cyc.size() && k < 3; k++) begin
      n_checks++;
      if (obs_start_cyc[k] != exp_start[k] || obs_start_idx[k] != k)
        $display("FAIL basic_start%0d got cyc=%0d idx=%0d want cyc=%0d idx=%0d", k, obs_start_cyc[k], obs_start_idx[k], exp_start[k], k);
      else n_pass++;
    end
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != exp_done) $display("FAIL basic_done got n=%0d cyc=%0d want n=1 cyc=%0d", obs_done_cyc.size(), (obs_done_cyc.size() > 0) ? obs_done_cyc[0] : -1, exp_done);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0 || o_frame_ready !== 1'b1) $display("FAIL basic_idle got busy=%b ready=%b want 0/1", o_busy, o_frame_ready);
    else n_pass++;
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
    n_checks++;
    if (o_frame_cycles !== 32'(exp_done)) $display("FAIL basic_cycles got=%0d want=%0d", o_frame_cycles, exp_done);
    else n_pass++;
`endif
    $display("test_basic num=3 done_cycle=%0d", exp_done);
  endtask

  task automatic test_zero_objects();
    run_frame(0, 0, 1'b0, 1'b0);
    n_checks++;
    if (obs_clr_addr.size() != FB || count_bad_clear() != 0) $display("FAIL zero_clear got n=%0d bad=%0d want n=%0d bad=0", obs_clr_addr.size(), count_bad_clear(), FB);
    else n_pass++;
    n_checks++;
    if (obs_start_cyc.size() != 0) $display("FAIL zero_no_start got=%0d want=0", obs_start_cyc.size());
    else n_pass++;
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != FB + 1) $display("FAIL zero_done got n=%0d cyc=%0d want n=1 cyc=%0d", obs_done_cyc.size(), (obs_done_cyc.size() > 0) ? obs_done_cyc[0] : -1, FB + 1);
    else n_pass++;
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
    n_checks++;
    if (o_frame_cycles !== 32'(FB + 1)) $display("FAIL zero_cycles got=%0d want=%0d", o_frame_cycles, FB + 1);
    else n_pass++;
`endif
    $display("test_zero_objects done_cycle=%0d", FB + 1);
  endtask

  task automatic test_pipe_stall();
    plan_w[0] = 50;                    plan_f[0] = $urandom_range(8, 1);
    plan_w[1] = $urandom_range(20, 0); plan_f[1] = $urandom_range(8, 1);
    run_frame(2, 2, 1'b0, 1'b0);
    n_checks++;
    if (obs_start_cyc.size() != 2) $display("FAIL stall_start_count got=%0d want=2", obs_start_cyc.size());
    else n_pass++;
    n_checks++;
    if (obs_start_cyc.size() < 1 || obs_start_cyc[0] != FB + 52) $display("FAIL stall_first_start got=%0d want=%0d", (obs_start_cyc.size() > 0) ? obs_start_cyc[0] : -1, FB + 52);
    else n_pass++;
    n_checks++;
    if (obs_start_cyc.size() < 2 || obs_start_cyc[1] != exp_start[1] || obs_start_idx[1] != 1) $display("FAIL stall_second_start got cyc=%0d want=%0d", (obs_start_cyc.size() > 1) ? obs_start_cyc[1] : -1, exp_start[1]);
    else n_pass++;
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != exp_done) $display("FAIL stall_done got=%0d want=%0d", (obs_done_cyc.size() > 0) ? obs_done_cyc[0] : -1, exp_done);
    else n_pass++;
    $display("test_pipe_stall w1=%0d done_cycle=%0d", plan_w[1], exp_done);
  endtask

  task automatic test_random_frames(input bit force_stale, input int iters);
    int n, bad;
    bit st;
    for (int it = 0; it < iters; it++) begin
      n  = $urandom_range(6, 2);
      st = force_stale | 1'($urandom_range(1, 0));
      for (int k = 0; k < n; k++) begin
        plan_w[k] = $urandom_range(4, 0);
        plan_f[k] = $urandom_range(12, 1);
      end
      run_frame(n, n, 1'b0, st);
      bad = 0;
      for (int k = 0; k < obs_start_cyc.size() && k < n; k++)
        if (obs_start_cyc[k] != exp_start[k] || obs_start_idx[k] != k) bad++;
      n_checks++;
      if (obs_start_cyc.size() != n || bad != 0) $display("FAIL rand%0d_starts got n=%0d bad=%0d want n=%0d bad=0", it, obs_start_cyc.size(), bad, n);
      else n_pass++;
      n_checks++;
      if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != exp_done) $display("FAIL rand%0d_done got=%0d want=%0d", it, (obs_done_cyc.size() > 0) ? obs_done_cyc[0] : -1, exp_done);
      else n_pass++;
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
      n_checks++;
      if (o_frame_cycles !== 32'(exp_done)) $display("FAIL rand%0d_cycles got=%0d want=%0d", it, o_frame_cycles, exp_done);
      else n_pass++;
`endif
      $display("test_random_frames it=%0d num=%0d stale=%0d done_cycle=%0d", it, n, st, exp_done);
    end
  endtask

  task automatic test_max_objects_held_valid();
    int bad = 0;
    for (int k = 0; k < MAXO; k++) begin plan_w[k] = 0; plan_f[k] = $urandom_range(3, 1); end
    run_frame(2000, MAXO, 1'b1, 1'b0);
    for (int k = 0; k < obs_start_cyc.size() && k < MAXO; k++)
      if (obs_start_cyc[k] != exp_start[k] || obs_start_idx[k] != k) bad++;
    n_checks++;
    if (obs_start_cyc.size() != MAXO || bad != 0) $display("FAIL max_starts got n=%0d bad=%0d want n=%0d bad=0", obs_start_cyc.size(), bad, MAXO);
    else n_pass++;
    n_checks++;
    if (timed_out || obs_done_cyc.size() != 1 || obs_done_cyc[0] != exp_done) $display("FAIL max_done got=%0d want=%0d", (obs_done_cyc.size() > 0) ? obs_done_cyc[0] : -1, exp_done);
    else n_pass++;
    n_checks++;
    if (obs_reaccept != exp_done + 1) $display("FAIL max_reaccept got=%0d want=%0d", obs_reaccept, exp_done + 1);
    else n_pass++;
    $display("test_max_objects_held_valid done_cycle=%0d reaccept=%0d", exp_done, obs_reaccept);
  endtask

  task automatic test_reset_mid_clear();
    int  guard = 0;
    bit  done_in_reset = 0;
    // The held request from the previous test started a new frame; run into its clear.
    while (o_clr_addr != AW'(500) && guard < 4 * FB) begin
      step();
      guard++;
    end
    n_checks++;
    if (o_clr_addr !== AW'(500) || o_clr_we !== 1'b1) $display("FAIL abort_reach500 got addr=%0d we=%b want 500/1", o_clr_addr, o_clr_we);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({o_clr_we, o_busy, o_obj_start, o_frame_done} !== 4'b0000 || o_clr_addr !== '0 || o_obj_index !== '0)
      $display("FAIL abort_outputs got we=%b busy=%b addr=%0d idx=%0d want 0/0/0/0", o_clr_we, o_busy, o_clr_addr, o_obj_index);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (o_frame_done) done_in_reset = 1;
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_frame_done) done_in_reset = 1;
    end
    n_checks++;
    if (done_in_reset) $display("FAIL abort_no_done got done pulse want none");
    else n_pass++;
`ifdef FRAME_SEQ_CYCLE_COUNT_EN
    n_checks++;
    if (o_frame_cycles !== 32'd0) $display("FAIL abort_cycles got=%0d want=0", o_frame_cycles);
    else n_pass++;
`endif
    plan_w[0] = $urandom_range(3, 0);
    plan_f[0] = $urandom_range(6, 1);
    run_frame(1, 1, 1'b0, 1'b0);
    n_checks++;
    if (obs_clr_addr.size() != FB || count_bad_clear() != 0) $display("FAIL abort_restart_clear got n=%0d bad=%0d want n=%0d bad=0", obs_clr_addr.size(), count_bad_clear(), FB);
    else n_pass++;
    n_checks++;
    if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != exp_done) $display("FAIL abort_restart_done got=%0d want=%0d", (obs_done_cyc.size() > 0) ? obs_done_cyc[0] : -1, exp_done);
    else n_pass++;
    $display("test_reset_mid_clear restart done_cycle=%0d", exp_done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_objects();
    test_pipe_stall();
    test_random_frames(1'b1, 2);
    test_random_frames(1'b0, 3);
    test_max_objects_held_valid();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
